// File: rtl/rr_index_arbiter_pkg.sv
// Shared definitions for the round-robin index arbiter.
// Optional feature macro: GRANT_TIMEOUT_EN (forced release after a hold limit).
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Default maximum grant hold length, used only with GRANT_TIMEOUT_EN.
    localparam int TIMEOUT_CYCLES_DEFAULT = 8;

    // Number of request lines arbitrated for an index width of n.
    function automatic int num_req(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/rr_index_arbiter_if.sv
// Request/grant bus between requesters and the round-robin index arbiter.
// Optional feature macro: GRANT_TIMEOUT_EN adds the timeout pulse.
//
// Handshake: req[k] is a level request from requester k. The arbiter answers
// with enable=1 and a=k (both registered). The grant is held until the owner
// pulses done for one cycle; done is only meaningful while enable=1. timeout
// pulses for one cycle when the arbiter forcibly ends a grant.
interface rr_index_arbiter_if #(
    parameter int N = 4
);
    logic [(1 << N)-1:0] req;
    logic                done;
    logic [N-1:0]        a;
    logic                enable;
`ifdef GRANT_TIMEOUT_EN
    logic                timeout;

    modport master (output req, output done, input a, input enable, input timeout);
    modport slave  (input req, input done, output a, output enable, output timeout);
`else
    modport master (output req, output done, input a, input enable);
    modport slave  (input req, input done, output a, output enable);
`endif
endinterface

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin search: first set req bit after ptr, wrapping,
// with ptr itself as the lowest-priority candidate.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [(1 << N)-1:0] req,
    input  logic [N-1:0]        ptr,
    output logic [N-1:0]        winner,
    output logic                any_valid
);

    // Scan ptr+1 .. ptr+2**N (mod 2**N); the first hit wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= (1 << N); i++) begin
            logic [N-1:0] idx;
            idx = ptr + N'(i);
            if (!any_valid && req[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter driving the index/enable of a one-hot decoder.
// Optional feature macro: GRANT_TIMEOUT_EN (grant forcibly released after
// TIMEOUT_CYCLES cycles without done, with a one-cycle timeout pulse).
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_index_arbiter_if.slave     bus,
    output state_t                state_dbg
);

    localparam int NUM_REQ = num_req(N);

    state_t       state_q, state_d;
    logic [N-1:0] ptr_q, ptr_d;
    logic [N-1:0] a_q, a_d;
    logic         enable_q, enable_d;

    logic [N-1:0] pick_ptr;
    logic [N-1:0] winner;
    logic         any_valid;
    logic         expire;

`ifdef GRANT_TIMEOUT_EN
    logic [7:0]   cnt_q, cnt_d;
    logic         timeout_q, timeout_d;

    // The grant has been held for TIMEOUT_CYCLES cycles once this edge passes.
    assign expire = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    // While granted, the release search starts right after the current owner.
    assign pick_ptr = (state_q == GRANT) ? a_q : ptr_q;

    rr_pick #(.N(N)) u_pick (
        .req       (bus.req),
        .ptr       (pick_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Next-state logic: grant from IDLE, hold or hand over in GRANT.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        enable_d = enable_q;
`ifdef GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d      = winner;
                    enable_d = 1'b1;
                    state_d  = GRANT;
`ifdef GRANT_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            GRANT: begin
                if (bus.done || expire) begin
                    ptr_d = a_q;
`ifdef GRANT_TIMEOUT_EN
                    timeout_d = expire && !bus.done;
                    cnt_d     = '0;
`endif
                    if (any_valid) begin
                        a_d = winner;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
`ifdef GRANT_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                enable_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; pointer resets so index 0 is first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= N'(NUM_REQ - 1);
            a_q      <= '0;
            enable_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            enable_q <= enable_d;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.a      = a_q;
    assign bus.enable = enable_q;
`ifdef GRANT_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`endif
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: table-driven vectors, hand sequences and a
// randomized phase checked against a small reference model.
module tb_rr_index_arbiter;
    import rr_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 3;

    logic   clk = 1'b0;
    logic   rst;
    state_t state_dbg;

    rr_index_arbiter_if #(.N(N)) bus ();

    rr_index_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Packed expectation: {timeout, enable, a}
    logic [5:0] exp_q[$];

    typedef struct packed {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        exp_en;
        logic [3:0]  exp_a;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] dut_out();
        logic to;
`ifdef GRANT_TIMEOUT_EN
        to = bus.timeout;
`else
        to = 1'b0;
`endif
        return {to, bus.enable, bus.a};
    endfunction

    // Driver: apply inputs away from the active edge, then wait past the edge.
    task automatic drive(input logic r, input logic [15:0] q, input logic d);
        @(negedge clk);
        rst      = r;
        bus.req  = q;
        bus.done = d;
    endtask

    task automatic step_and_compare(input string name);
        logic [5:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, 32'(dut_out()), 32'(e));
    endtask

    // Reference model
    logic [3:0] m_ptr, m_a;
    logic       m_st;
    int         m_cnt;

    function automatic logic [4:0] model_pick(input logic [15:0] r, input logic [3:0] p);
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] idx;
            idx = p + 4'(i);
            if (r[idx]) return {1'b1, idx};
        end
        return 5'b0;
    endfunction

    task automatic model_step(input logic r, input logic [15:0] q, input logic d, output logic to);
        logic [4:0] pk;
        logic       exp_hit;
        to = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        exp_hit = (m_cnt == TO - 1);
`else
        exp_hit = 1'b0;
`endif
        if (r) begin
            m_st = 1'b0; m_ptr = 4'hF; m_a = 4'h0; m_cnt = 0;
        end else if (!m_st) begin
            pk = model_pick(q, m_ptr);
            if (pk[4]) begin m_st = 1'b1; m_a = pk[3:0]; m_cnt = 0; end
        end else if (d || exp_hit) begin
            m_ptr = m_a;
            to = !d && exp_hit;
            m_cnt = 0;
            pk = model_pick(q, m_a);
            if (pk[4]) m_a = pk[3:0];
            else m_st = 1'b0;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        logic       to;
        logic       seen;
        logic [3:0] k;
        logic [15:0] rq;
        logic        r, d;

        rst = 1'b1;
        bus.req = '0;
        bus.done = 1'b0;

        vecs[0]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd1};
        vecs[5]  = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd2};
        vecs[6]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 16'h0001, 1'b0, 1'b1, 4'd0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 16'h8421, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 16'h8421, 1'b0, 1'b1, 4'd0};
        vecs[14] = '{1'b0, 16'h8421, 1'b1, 1'b1, 4'd5};
        vecs[15] = '{1'b0, 16'h8421, 1'b0, 1'b1, 4'd5};
        vecs[16] = '{1'b0, 16'h8421, 1'b1, 1'b1, 4'd10};
        vecs[17] = '{1'b0, 16'h8421, 1'b1, 1'b1, 4'd15};
        vecs[18] = '{1'b0, 16'h8421, 1'b1, 1'b1, 4'd0};
        vecs[19] = '{1'b0, 16'h0010, 1'b1, 1'b1, 4'd4};
        vecs[20] = '{1'b0, 16'h0010, 1'b1, 1'b1, 4'd4};
        vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd4};
        vecs[22] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd4};
        vecs[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd4};
        vecs[24] = '{1'b0, 16'h0080, 1'b0, 1'b1, 4'd7};
        vecs[25] = '{1'b1, 16'h0080, 1'b0, 1'b0, 4'd0};
        vecs[26] = '{1'b0, 16'h0080, 1'b0, 1'b1, 4'd7};
        vecs[27] = '{1'b0, 16'h0100, 1'b1, 1'b1, 4'd8};
        vecs[28] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd8};
        vecs[29] = '{1'b0, 16'h0201, 1'b0, 1'b1, 4'd9};
        vecs[30] = '{1'b0, 16'h0201, 1'b1, 1'b1, 4'd0};
        vecs[31] = '{1'b0, 16'h0201, 1'b1, 1'b1, 4'd9};

        // Table-driven vectors
        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].done);
            exp_q.push_back({1'b0, vecs[i].exp_en, vecs[i].exp_a});
            step_and_compare($sformatf("vec%0d_out", i));
            check($sformatf("vec%0d_state", i), 32'(state_dbg),
                  32'(vecs[i].exp_en ? GRANT : IDLE));
        end

`ifdef GRANT_TIMEOUT_EN
        // Forced release after TO cycles without done.
        drive(1'b1, 16'h0000, 1'b0);
        exp_q.push_back(6'b0_0_0000);
        step_and_compare("to_reset");
        drive(1'b0, 16'h0006, 1'b0);
        exp_q.push_back(6'b0_1_0001);
        step_and_compare("to_grant1");
        for (int i = 0; i < TO - 1; i++) begin
            drive(1'b0, 16'h0006, 1'b0);
            exp_q.push_back(6'b0_1_0001);
            step_and_compare($sformatf("to_hold%0d", i));
        end
        drive(1'b0, 16'h0006, 1'b0);
        exp_q.push_back(6'b1_1_0010);
        step_and_compare("to_pulse");
        drive(1'b0, 16'h0006, 1'b0);
        exp_q.push_back(6'b0_1_0010);
        step_and_compare("to_after");
`else
        // Grant held indefinitely with no done, even after req drops.
        drive(1'b1, 16'h0000, 1'b0);
        exp_q.push_back(6'b0_0_0000);
        step_and_compare("hold_reset");
        drive(1'b0, 16'h0008, 1'b0);
        exp_q.push_back(6'b0_1_0011);
        step_and_compare("hold_grant");
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 16'h0000, 1'b0);
            exp_q.push_back(6'b0_1_0011);
            step_and_compare($sformatf("hold_%0d", i));
        end
`endif

        // Bounded wait for a grant to a random single requester.
        drive(1'b1, 16'h0000, 1'b0);
        @(posedge clk);
        k = 4'($urandom_range(0, 15));
        drive(1'b0, 16'h0001 << k, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.enable) seen = 1'b1;
        end
        check("wait_enable", 32'(seen), 32'd1);
        check("wait_index", 32'(bus.a), 32'(k));

        // Randomized phase against the reference model.
        drive(1'b1, 16'h0000, 1'b0);
        model_step(1'b1, 16'h0000, 1'b0, to);
        exp_q.push_back({to, m_st, m_a});
        step_and_compare("rand_reset");
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            rq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            d  = ($urandom_range(0, 2) == 0);
            drive(r, rq, d);
            model_step(r, rq, d, to);
            exp_q.push_back({to, m_st, m_a});
            step_and_compare($sformatf("rand%0d", i));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "time limit");
    end

endmodule
